// File: rtl/qsfp_link_ctrl.sv
// QSFP cage + GTX quad bring-up sequencer: presence debounce, sideband sequencing,
// transceiver reset/usrrdy control and alignment supervision. Optional macro: QSFP_INTL_EN.
module qsfp_link_ctrl #(
  parameter int CHAN          = 4,
  parameter int CW            = 24,
  parameter int DEBOUNCE      = 1000,
  parameter int RESET_CYCLES  = 2000,
  parameter int INIT_CYCLES   = 200000,
  parameter int GT_RST_CYCLES = 64,
  parameter int ALIGN_TIMEOUT = 1000000,
  parameter int MAX_RETRY     = 3
) (
  input  logic            sysclk,
  input  logic            soft_reset,
  input  logic            qsfp_modprsl,
  input  logic            qsfp_intl,
  input  logic [CHAN-1:0] rxbyteisaligned,
  input  logic [CHAN-1:0] cfg_lane_en,
  input  logic            cfg_lpmode,
  input  logic            cfg_restart,
  input  logic            irq_clr,
  output logic            qsfp_resetl,
  output logic            qsfp_lpmode,
  output logic            qsfp_modsel,
  output logic            gt_soft_reset,
  output logic [CHAN-1:0] gt_txusrrdy,
  output logic [CHAN-1:0] gt_rxusrrdy,
  output logic            link_up,
  output logic [2:0]      state,
  output logic [3:0]      retry_cnt,
  output logic            irq
);
  typedef enum logic [2:0] {
    ST_ABSENT = 3'd0, ST_MOD_RST = 3'd1, ST_MOD_INIT = 3'd2, ST_GT_RST = 3'd3,
    ST_ALIGN  = 3'd4, ST_UP      = 3'd5, ST_FAULT    = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   timer_q, timer_d, db_cnt_q, db_cnt_d;
  logic [3:0]      retry_q, retry_d, retry_inc;
  logic [1:0]      prs_sync_q;
  logic [CHAN-1:0] al_s1_q, al_s2_q;
  logic            present_q, present_d, load, lanes_ok, lane_lost;
  logic            resetl_d, lpmode_d, modsel_d, gt_rst_d, link_up_d;
  logic [CHAN-1:0] usrrdy_d;

  always_ff @(posedge sysclk) begin
    if (soft_reset) begin
      prs_sync_q    <= 2'b11;
      al_s1_q       <= '0;
      al_s2_q       <= '0;
      present_q     <= 1'b0;
      db_cnt_q      <= '0;
      state_q       <= ST_ABSENT;
      timer_q       <= '0;
      retry_q       <= '0;
      qsfp_resetl   <= 1'b0;
      qsfp_lpmode   <= 1'b1;
      qsfp_modsel   <= 1'b1;
      gt_soft_reset <= 1'b1;
      gt_txusrrdy   <= '0;
      gt_rxusrrdy   <= '0;
      link_up       <= 1'b0;
    end else begin
      prs_sync_q    <= {prs_sync_q[0], qsfp_modprsl};
      al_s1_q       <= rxbyteisaligned;
      al_s2_q       <= al_s1_q;
      present_q     <= present_d;
      db_cnt_q      <= db_cnt_d;
      state_q       <= state_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      qsfp_resetl   <= resetl_d;
      qsfp_lpmode   <= lpmode_d;
      qsfp_modsel   <= modsel_d;
      gt_soft_reset <= gt_rst_d;
      gt_txusrrdy   <= usrrdy_d;
      gt_rxusrrdy   <= usrrdy_d;
      link_up       <= link_up_d;
    end
  end

  // Synced ModPrsL equal to present_q means the pin disagrees with the accepted presence.
  always_comb begin
    present_d = present_q;
    db_cnt_d  = '0;
    if (prs_sync_q[1] == present_q) begin
      if (db_cnt_q == CW'(DEBOUNCE - 1)) present_d = ~present_q;
      else db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    load      = 1'b0;
    timer_d   = (timer_q != '0) ? timer_q - 1'b1 : '0;
    lanes_ok  = ((al_s2_q & cfg_lane_en) == cfg_lane_en) && (cfg_lane_en != '0);
    lane_lost = |(~al_s2_q & cfg_lane_en);
    retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
    if (state_q != ST_ABSENT && !present_q) begin
      state_d = ST_ABSENT;
    end else if (state_q != ST_ABSENT && cfg_restart) begin
      state_d = ST_MOD_RST;
      retry_d = '0;
      load    = 1'b1;
    end else begin
      case (state_q)
        ST_ABSENT:   if (present_q) begin state_d = ST_MOD_RST; load = 1'b1; end
        ST_MOD_RST:  if (timer_q == '0) begin state_d = ST_MOD_INIT; load = 1'b1; end
        ST_MOD_INIT: if (timer_q == '0) begin state_d = ST_GT_RST; load = 1'b1; end
        ST_GT_RST:   if (timer_q == '0) begin state_d = ST_ALIGN; load = 1'b1; end
        ST_ALIGN: begin
          if (lanes_ok) begin
            state_d = ST_UP;
            retry_d = '0;
            load    = 1'b1;
          end else if (timer_q == '0) begin
            retry_d = retry_inc;
            state_d = (int'(retry_inc) < MAX_RETRY) ? ST_GT_RST : ST_FAULT;
            load    = 1'b1;
          end
        end
        ST_UP:       if (lane_lost) begin state_d = ST_GT_RST; load = 1'b1; end
        ST_FAULT:    state_d = ST_FAULT;
        default:     state_d = ST_ABSENT;
      endcase
    end
    if (load) begin
      case (state_d)
        ST_MOD_RST:  timer_d = CW'(RESET_CYCLES - 1);
        ST_MOD_INIT: timer_d = CW'(INIT_CYCLES - 1);
        ST_GT_RST:   timer_d = CW'(GT_RST_CYCLES - 1);
        ST_ALIGN:    timer_d = CW'(ALIGN_TIMEOUT - 1);
        default:     timer_d = '0;
      endcase
    end
  end

  // Outputs decode the next state so they register on the same edge as state.
  always_comb begin
    resetl_d  = !(state_d == ST_ABSENT || state_d == ST_MOD_RST);
    lpmode_d  = (state_d == ST_UP) ? cfg_lpmode : 1'b1;
    modsel_d  = (state_d == ST_ABSENT);
    gt_rst_d  = !(state_d == ST_ALIGN || state_d == ST_UP);
    usrrdy_d  = (state_d == ST_ALIGN || state_d == ST_UP) ? '1 : '0;
    link_up_d = (state_d == ST_UP);
  end

  assign state     = state_q;
  assign retry_cnt = retry_q;

`ifdef QSFP_INTL_EN
  logic [1:0] intl_sync_q;
  logic       intl_prev_q, irq_q, irq_d;

  always_ff @(posedge sysclk) begin
    if (soft_reset) begin
      intl_sync_q <= 2'b11;
      intl_prev_q <= 1'b1;
      irq_q       <= 1'b0;
    end else begin
      intl_sync_q <= {intl_sync_q[0], qsfp_intl};
      intl_prev_q <= intl_sync_q[1];
      irq_q       <= irq_d;
    end
  end

  // A set in the same cycle as irq_clr wins.
  always_comb begin
    irq_d = irq_q;
    if (irq_clr) irq_d = 1'b0;
    if ((intl_prev_q && !intl_sync_q[1] && state_q >= ST_MOD_INIT) ||
        (state_d == ST_FAULT && state_q != ST_FAULT))
      irq_d = 1'b1;
  end

  assign irq = irq_q;
`else
  logic unused_intl;
  assign unused_intl = ^{qsfp_intl, irq_clr};
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_qsfp_link_ctrl.sv
// Directed bench for qsfp_link_ctrl with small timing parameters; state transitions are
// scoreboarded through an expected-state queue against a negedge state monitor.
module tb_qsfp_link_ctrl;
  localparam int CHAN = 4;
`ifdef QSFP_INTL_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic            sysclk = 1'b0;
  logic            soft_reset, qsfp_modprsl, qsfp_intl, cfg_lpmode, cfg_restart, irq_clr;
  logic [CHAN-1:0] rxbyteisaligned, cfg_lane_en;
  logic            qsfp_resetl, qsfp_lpmode, qsfp_modsel, gt_soft_reset, link_up, irq;
  logic [CHAN-1:0] gt_txusrrdy, gt_rxusrrdy;
  logic [2:0]      state;
  logic [3:0]      retry_cnt;

  int         total = 0;
  int         bad = 0;
  logic [2:0] exp_q[$];
  logic [2:0] obs_q[$];
  logic [2:0] last_state = 3'd0;
  int         cyc_in[8];
  int         rst_low = 0;
  int         n;

  always #5 sysclk = ~sysclk;

  qsfp_link_ctrl #(
    .CHAN(CHAN), .CW(24), .DEBOUNCE(4), .RESET_CYCLES(8), .INIT_CYCLES(16),
    .GT_RST_CYCLES(4), .ALIGN_TIMEOUT(32), .MAX_RETRY(3)
  ) dut (
    .sysclk(sysclk), .soft_reset(soft_reset), .qsfp_modprsl(qsfp_modprsl),
    .qsfp_intl(qsfp_intl), .rxbyteisaligned(rxbyteisaligned), .cfg_lane_en(cfg_lane_en),
    .cfg_lpmode(cfg_lpmode), .cfg_restart(cfg_restart), .irq_clr(irq_clr),
    .qsfp_resetl(qsfp_resetl), .qsfp_lpmode(qsfp_lpmode), .qsfp_modsel(qsfp_modsel),
    .gt_soft_reset(gt_soft_reset), .gt_txusrrdy(gt_txusrrdy), .gt_rxusrrdy(gt_rxusrrdy),
    .link_up(link_up), .state(state), .retry_cnt(retry_cnt), .irq(irq)
  );

  // State-change monitor and per-state cycle accounting.
  always @(negedge sysclk) begin
    if (!$isunknown(state)) begin
      if (state !== last_state) begin
        obs_q.push_back(state);
        last_state = state;
      end
      cyc_in[state] = cyc_in[state] + 1;
      if (state == 3'd1 && qsfp_resetl == 1'b0) rst_low = rst_low + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int k);
    repeat (k) @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input int budget);
    logic [2:0] e, o;
    int k = 0;
    e = exp_q.pop_front();
    while (obs_q.size() == 0 && k < budget) begin
      tick(1);
      k++;
    end
    if (obs_q.size() != 0) o = obs_q.pop_front();
    else o = 3'bxxx;
    chk(tag, {29'd0, o}, {29'd0, e});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(tag, {state, retry_cnt, qsfp_resetl, qsfp_lpmode, qsfp_modsel, gt_soft_reset,
              gt_txusrrdy, gt_rxusrrdy, link_up, irq},
             {3'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0});
  endtask

  task automatic clr_cyc();
    foreach (cyc_in[i]) cyc_in[i] = 0;
    rst_low = 0;
  endtask

  initial begin
    soft_reset = 1'b1; qsfp_modprsl = 1'b1; qsfp_intl = 1'b1; rxbyteisaligned = '0;
    cfg_lane_en = 4'hF; cfg_lpmode = 1'b0; cfg_restart = 1'b0; irq_clr = 1'b0;
    tick(3);
    chk_reset_vals("reset_values");
    soft_reset = 1'b0;
    obs_q.delete();
    tick(2);

    // Presence glitch shorter than the debounce window.
    qsfp_modprsl = 1'b0; tick(3); qsfp_modprsl = 1'b1; tick(20);
    chk("glitch_state", state, 0);
    chk("glitch_no_change", obs_q.size(), 0);

    // Insertion with all lanes aligned.
    rxbyteisaligned = 4'hF; clr_cyc();
    for (int s = 1; s <= 5; s++) exp_q.push_back(3'(s));
    qsfp_modprsl = 1'b0;
    n = 0;
    while (state != 3'd1 && n < 50) begin tick(1); n++; end
    chk("presence_latency", n, 7);
    sb_check("ins_mod_rst", 5);
    sb_check("ins_mod_init", 20);
    sb_check("ins_gt_rst", 30);
    sb_check("ins_align", 10);
    sb_check("ins_up", 10);
    chk("resetl_low_cycles", rst_low, 8);
    chk("mod_init_cycles", cyc_in[2], 16);
    chk("gt_rst_cycles", cyc_in[3], 4);
    chk("align_cycles", cyc_in[4], 1);
    chk("up_outputs", {link_up, gt_soft_reset, qsfp_resetl, qsfp_modsel, qsfp_lpmode,
                       gt_txusrrdy, gt_rxusrrdy},
                      {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF});
    cfg_lpmode = 1'b1; tick(1);
    chk("lpmode_follow_1", qsfp_lpmode, 1);
    cfg_lpmode = 1'b0; tick(1);
    chk("lpmode_follow_0", qsfp_lpmode, 0);

    // One-cycle loss of lane 0 alignment in UP.
    exp_q.push_back(3'd3); exp_q.push_back(3'd4); exp_q.push_back(3'd5);
    rxbyteisaligned[0] = 1'b0; tick(1); rxbyteisaligned[0] = 1'b1; tick(2);
    chk("lane_drop_gt_rst", state, 3);
    chk("lane_drop_retry", retry_cnt, 0);
    sb_check("drop_gt_rst", 5);
    sb_check("drop_align", 10);
    sb_check("drop_up", 10);
    chk("drop_relink", {link_up, retry_cnt}, {1'b1, 4'd0});

    // Lane 1 never aligns: retries then FAULT.
    exp_q.push_back(3'd1);
    cfg_restart = 1'b1; tick(1); cfg_restart = 1'b0;
    sb_check("restart_mod_rst", 5);
    cfg_lane_en = 4'b0011; rxbyteisaligned = 4'b0001; clr_cyc();
    exp_q.push_back(3'd2);
    for (int p = 0; p < 3; p++) begin exp_q.push_back(3'd3); exp_q.push_back(3'd4); end
    exp_q.push_back(3'd6);
    for (int i = 0; i < 8; i++) sb_check($sformatf("fault_seq%0d", i), 60);
    chk("fault_gt_rst_cycles", cyc_in[3], 12);
    chk("fault_align_cycles", cyc_in[4], 96);
    chk("fault_retry", retry_cnt, 3);
    chk("fault_outputs", {gt_soft_reset, gt_txusrrdy, gt_rxusrrdy, link_up, qsfp_resetl, qsfp_modsel},
                         {1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0});
    chk("fault_irq", irq, IRQ_ON);
    irq_clr = 1'b1; tick(1); irq_clr = 1'b0;
    chk("irq_clear", irq, 0);
    qsfp_intl = 1'b0; tick(4);
    chk("irq_intl_fall", irq, IRQ_ON);
    qsfp_intl = 1'b1; irq_clr = 1'b1; tick(1); irq_clr = 1'b0; tick(3);
    chk("irq_clear2", irq, 0);

    // Removal during MOD_INIT coinciding with a restart request.
    exp_q.push_back(3'd1);
    cfg_restart = 1'b1; tick(1); cfg_restart = 1'b0;
    sb_check("fault_restart", 5);
    chk("restart_clears_retry", retry_cnt, 0);
    exp_q.push_back(3'd2);
    sb_check("mi_enter", 20);
    exp_q.push_back(3'd0);
    qsfp_modprsl = 1'b1; tick(6); cfg_restart = 1'b1; tick(1); cfg_restart = 1'b0;
    chk("remove_outputs", {state, qsfp_modsel, qsfp_resetl}, {3'd0, 1'b1, 1'b0});
    sb_check("remove_absent", 5);
    cfg_restart = 1'b1; tick(1); cfg_restart = 1'b0; tick(3);
    chk("restart_in_absent", {obs_q.size(), state}, {32'd0, 3'd0});

    // Soft reset while UP, then automatic re-sequencing.
    cfg_lane_en = 4'hF; rxbyteisaligned = 4'hF;
    for (int s = 1; s <= 5; s++) exp_q.push_back(3'(s));
    qsfp_modprsl = 1'b0;
    sb_check("re_mod_rst", 20);
    sb_check("re_mod_init", 20);
    sb_check("re_gt_rst", 30);
    sb_check("re_align", 10);
    sb_check("re_up", 10);
    exp_q.push_back(3'd0);
    soft_reset = 1'b1; tick(1);
    chk_reset_vals("soft_reset_in_up");
    soft_reset = 1'b0;
    sb_check("rst_absent", 5);
    exp_q.push_back(3'd1);
    sb_check("rst_reinsert", 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
